// File: rtl/bilin_pkg.sv
// Shared defaults and FSM encoding for the horizontal bilinear interpolator.
package bilin_pkg;
  localparam int BILIN_DW     = 8;
  localparam int BILIN_FRAC_W = 8;
  localparam int BILIN_LEN_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/bilin_lerp.sv
// Two-stage lerp: stage 1 multiplies both taps, stage 2 adds, rounds and shifts; 2-cycle latency.
// The whole pipe freezes while out_vld_o is held against out_rdy_i low, so out_pix_o stays stable.
module bilin_lerp
  import bilin_pkg::*;
#(
  parameter int DW     = BILIN_DW,
  parameter int FRAC_W = BILIN_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld_i,
  input  logic              in_last_i,
  input  logic [DW-1:0]     p0_i,
  input  logic [DW-1:0]     p1_i,
  input  logic [FRAC_W-1:0] phase_i,
  input  logic              out_rdy_i,
  output logic              stall_o,
  output logic              out_vld_o,
  output logic              out_last_o,
  output logic [DW-1:0]     out_pix_o,
  output logic              busy_o
);
  localparam int IW = DW + FRAC_W + 1;

  logic          s1_vld_q, s1_last_q;
  logic          out_vld_q, out_last_q;
  logic [IW-1:0] prod0_q, prod1_q, prod0_d, prod1_d, sum;
  logic [DW-1:0] pix_q, pix_d;

  assign stall_o = out_vld_q && !out_rdy_i;

  // Weight of p0 is (1.0 - phase), which needs FRAC_W+1 bits when phase is 0.
  assign prod0_d = IW'(p0_i) * ((IW'(1) << FRAC_W) - IW'(phase_i));
  assign prod1_d = IW'(p1_i) * IW'(phase_i);
  assign sum     = prod0_q + prod1_q + (IW'(1) << (FRAC_W - 1));
  assign pix_d   = DW'(sum >> FRAC_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      prod0_q    <= '0;
      prod1_q    <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      pix_q      <= '0;
    end else if (!stall_o) begin
      s1_vld_q   <= in_vld_i;
      s1_last_q  <= in_vld_i && in_last_i;
      if (in_vld_i) begin
        prod0_q <= prod0_d;
        prod1_q <= prod1_d;
      end
      out_vld_q  <= s1_vld_q;
      out_last_q <= s1_last_q;
      if (s1_vld_q) pix_q <= pix_d;
    end
  end

  assign out_vld_o  = out_vld_q;
  assign out_last_o = out_last_q;
  assign out_pix_o  = pix_q;
  assign busy_o     = s1_vld_q || out_vld_q;
endmodule

// File: rtl/bilinear_h_interp.sv
// Horizontal bilinear line resampler: one output per issue, 2-cycle issue-to-out_valid latency.
// Issue, phase and count all stall while out_valid is held with out_ready low or the pair FIFO is empty.
module bilinear_h_interp
  import bilin_pkg::*;
#(
  parameter int DW     = BILIN_DW,
  parameter int FRAC_W = BILIN_FRAC_W,
  parameter int LEN_W  = BILIN_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FRAC_W-1:0] step,
  input  logic [LEN_W-1:0]  out_len,
  input  logic [2*DW-1:0]   fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_pix,
  output logic              busy,
  output logic              line_done
);
  state_e            state_q, state_d;
  logic [FRAC_W-1:0] step_q, step_d, phase_q, phase_d, phase_sum;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic              stall, issue, last_issue, carry, lerp_busy, out_last;

  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, step_q};
  assign issue      = (state_q == ST_RUN) && !fifo_empty && !stall;
  assign last_issue = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    len_d      = len_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (step != '0) && (out_len != '0)) begin
          state_d = ST_RUN;
          step_d  = step;
          len_d   = out_len;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          phase_d = phase_sum;
          cnt_d   = cnt_q + LEN_W'(1);
          // Pop once the phase wraps past p1, and always release the pair under the last output.
          fifo_rd_en = carry || last_issue;
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (line_done || !lerp_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  bilin_lerp #(
    .DW     (DW),
    .FRAC_W (FRAC_W)
  ) u_lerp (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld_i   (issue),
    .in_last_i  (last_issue),
    .p0_i       (fifo_rd_data[2*DW-1:DW]),
    .p1_i       (fifo_rd_data[DW-1:0]),
    .phase_i    (phase_q),
    .out_rdy_i  (out_ready),
    .stall_o    (stall),
    .out_vld_o  (out_valid),
    .out_last_o (out_last),
    .out_pix_o  (out_pix),
    .busy_o     (lerp_busy)
  );

  assign busy      = (state_q != ST_IDLE);
  assign line_done = out_valid && out_ready && out_last;
endmodule

// File: tb/tb_bilinear_h_interp.sv
// Directed and randomized lines checked against a position-based resampling model.
module tb_bilinear_h_interp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  step;
  logic [11:0] out_len;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pix;
  logic        busy;
  logic        line_done;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          gate = 0;
  bit          pop_pend = 0;
  bit          stall_prev = 0;
  logic [7:0]  pix_prev;
  logic [15:0] pair_q[$];
  logic [15:0] line_pairs[$];
  int          got_q[$];

  bilinear_h_interp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .step         (step),
    .out_len      (out_len),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pix      (out_pix),
    .busy         (busy),
    .line_done    (line_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty   = (gate > 0) || (pair_q.size() == 0);
    fifo_rd_data = (pair_q.size() > 0) ? pair_q[0] : 16'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pend) begin
      if (pair_q.size() > 0) void'(pair_q.pop_front());
      pop_pend = 0;
    end
    if (gate > 0) gate--;
    drive_fifo();
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_vld", out_valid, 1);
        check("hold_pix", out_pix, pix_prev);
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        pop_pend = 1;
        check("rd_en_empty", fifo_empty, 0);
      end
      if (out_valid && out_ready) got_q.push_back(int'(out_pix));
      if (line_done) done_cnt++;
      stall_prev = out_valid && !out_ready;
      pix_prev   = out_pix;
    end else begin
      stall_prev = 0;
    end
  end

  // Output k sits at position k*step (in 1/256 units): integer part picks the pair, fraction weights it.
  task automatic run_line(input int stp, input int len, input int rmode, input int gcyc,
                          input bit poke, input bit rand_pairs);
    int exp_q[$];
    int npairs, base_done, base_rd, s_cyc, first_ne, first_vld, hold, budget;
    bit seen;
    npairs = ((len - 1) * stp) / 256 + 1;
    if (rand_pairs) begin
      line_pairs = {};
      for (int i = 0; i < npairs; i++) line_pairs.push_back(16'($urandom));
    end
    for (int k = 0; k < len; k++) begin
      int pos, idx, ph, a, b;
      pos = k * stp;
      idx = pos / 256;
      ph  = pos % 256;
      a   = int'(line_pairs[idx][15:8]);
      b   = int'(line_pairs[idx][7:0]);
      exp_q.push_back((a * (256 - ph) + b * ph + 128) / 256);
    end
    got_q = {};
    base_done = done_cnt;
    base_rd   = rd_cnt;
    pair_q    = line_pairs;
    gate      = (gcyc > 0) ? gcyc + 1 : 0;
    out_ready = 1;
    start = 1; step = 8'(stp); out_len = 12'(len);
    drive_fifo();
    s_cyc = cyc;
    tick();
    start = 0;
    check("busy_run", busy, 1);
    first_ne = -1; first_vld = -1; seen = 0; hold = 0; budget = 0;
    while (done_cnt == base_done && budget < 2000) begin
      if (first_ne < 0 && !fifo_empty) first_ne = cyc;
      if (first_vld < 0 && out_valid) first_vld = cyc;
      if (gate > 0) begin
        check("gate_vld", out_valid, 0);
        check("gate_rd", fifo_rd_en, 0);
      end
      if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (rmode == 2) begin
        if (!seen && out_valid) begin seen = 1; hold = 3; end
        out_ready = (hold == 0);
        if (hold > 0) hold--;
      end
      if (poke && cyc == s_cyc + 3) begin
        start = 1; step = 8'h11; out_len = 12'd7;
      end else start = 0;
      tick();
      budget++;
    end
    start = 0;
    out_ready = 1;
    check("line_timeout", (budget < 2000), 1);
    check("latency", first_vld - first_ne, 2);
    if (gcyc > 0) check("gate_len", first_ne - s_cyc, gcyc + 1);
    repeat (3) tick();
    check("done_once", done_cnt - base_done, 1);
    check("busy_idle", busy, 0);
    check("out_count", got_q.size(), len);
    check("pop_count", rd_cnt - base_rd, npairs);
    check("fifo_drained", pair_q.size(), 0);
    for (int i = 0; i < len; i++)
      check("pix", (got_q.size() > i) ? got_q[i] : -1, exp_q[i]);
  endtask

  initial begin
    int base_rd, base_done, budget;
    rst_n = 0; start = 0; step = 0; out_len = 0;
    fifo_empty = 1; fifo_rd_data = 0; out_ready = 1;
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_pix", out_pix, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_done", line_done, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    tick();

    line_pairs = {16'h0A1E};
    run_line(8'h80, 2, 0, 0, 0, 0);
    line_pairs = {16'h00FF};
    run_line(8'h40, 4, 0, 0, 0, 0);
    line_pairs = {16'h0A1E, 16'h2850};
    run_line(8'h80, 4, 2, 0, 0, 0);
    line_pairs = {16'h0A1E, 16'h2850};
    run_line(8'h80, 4, 0, 5, 0, 0);
    line_pairs = {16'h0A1E, 16'h2850};
    run_line(8'h80, 4, 0, 0, 1, 0);
    line_pairs = {16'h4DC8};
    run_line(8'h01, 1, 0, 0, 0, 0);
    line_pairs = {16'hFFFF};
    run_line(8'h33, 5, 0, 0, 0, 0);

    // Starts with a zero step or zero length must leave the block idle.
    base_rd = rd_cnt;
    pair_q = {16'h1234};
    drive_fifo();
    start = 1; step = 8'h00; out_len = 12'd3;
    tick();
    start = 0;
    check("zstep_busy", busy, 0);
    start = 1; step = 8'h40; out_len = 12'd0;
    tick();
    start = 0;
    repeat (3) tick();
    check("zlen_busy", busy, 0);
    check("zero_no_pop", rd_cnt - base_rd, 0);
    pair_q = {};

    // Reset in the middle of a line.
    line_pairs = {16'h0A1E, 16'h2850};
    pair_q = line_pairs;
    got_q = {};
    base_done = done_cnt;
    start = 1; step = 8'h80; out_len = 12'd4;
    drive_fifo();
    tick();
    start = 0;
    budget = 0;
    while (got_q.size() < 1 && budget < 200) begin tick(); budget++; end
    check("rst_wait", (budget < 200), 1);
    rst_n = 0;
    #1;
    check("mrst_vld", out_valid, 0);
    check("mrst_pix", out_pix, 0);
    check("mrst_busy", busy, 0);
    check("mrst_rd_en", fifo_rd_en, 0);
    check("mrst_done", line_done, 0);
    repeat (2) tick();
    rst_n = 1;
    base_rd = rd_cnt;
    pair_q = {16'h1111};
    repeat (4) tick();
    check("post_rst_pop", rd_cnt - base_rd, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done_cnt - base_done, 0);
    pair_q = {};
    line_pairs = {16'h0A1E, 16'h2850};
    run_line(8'h80, 4, 0, 0, 0, 0);

    for (int r = 0; r < 8; r++)
      run_line($urandom_range(1, 255), $urandom_range(1, 24), 1,
               $urandom_range(0, 1) * $urandom_range(1, 4), 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bilinear_h_interp.md
BILINEAR_H_INTERP -- requirements
Module: bilinear_h_interp

Interface
REQ-001 SHALL have parameter DW, default 8, pixel width.
REQ-002 SHALL have parameter FRAC_W, default 8, phase and step fraction width.
REQ-003 SHALL have parameter LEN_W, default 12, output-pixels-per-line counter width.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse, begin one line
  step  in  FRAC_W  phase increment per output, unsigned fraction of 1.0, latched on start
  out_len  in  LEN_W  output pixels this line, latched on start
  fifo_rd_data  in  2*DW  pixel pair {p0[2DW-1:DW], p1[DW-1:0]} from pair FIFO, combinational
  fifo_empty  in  1  pair FIFO empty
  fifo_rd_en  out  1  pop one pair
  out_valid  out  1  out_pix valid
  out_ready  in  1  downstream accepts
  out_pix  out  DW  interpolated pixel
  busy  out  1  line in progress or pipeline not drained
  line_done  out  1  one-cycle pulse, last pixel of line accepted

Function
REQ-005 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on start with step!=0 and out_len!=0; otherwise start ignored.
REQ-006 SHALL ignore start outside IDLE.
REQ-007 SHALL clear phase (FRAC_W bits) and output counter on entry to RUN.
REQ-008 In RUN an issue SHALL occur in a cycle when fifo_empty=0 and the pipeline is not stalled; no issue when fifo_empty=1.
REQ-009 Each issue SHALL compute out = (p0*(2^FRAC_W - phase) + p1*phase + 2^(FRAC_W-1)) >> FRAC_W using DW+FRAC_W+1-bit intermediates; result SHALL fit DW bits without saturation.
REQ-010 Per issue phase SHALL become (phase+step) mod 2^FRAC_W; fifo_rd_en SHALL be 1 in that same cycle iff the add carries out or the issue is the line's last output.
REQ-011 fifo_rd_en SHALL never be asserted when fifo_empty=1 or outside an issue cycle.
REQ-012 After issuing the out_len-th output, FSM SHALL go RUN->DRAIN; DRAIN->IDLE when the pipeline is empty; line_done SHALL pulse in the cycle the last pixel handshakes.
REQ-013 Latency SHALL be 2 cycles from issue to out_valid (stage 1 multiply, stage 2 add/round/shift), no stalls.
REQ-014 While out_valid=1 and out_ready=0, the pipeline, phase, counter and issue SHALL stall; out_pix SHALL hold stable.
REQ-015 Throughput SHALL be one pixel per cycle when fifo_empty=0 and out_ready=1.
REQ-016 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, phase 0, counter 0, pipeline valids 0, out_valid 0, out_pix 0, fifo_rd_en 0, busy 0, line_done 0.
REQ-018 Reset mid-line SHALL abandon the line without line_done; no pop after reset until next start.

Structure
REQ-019 Package bilin_pkg SHALL hold DW, FRAC_W, LEN_W defaults and the FSM state encoding.
REQ-020 2-stage lerp datapath with its valid/stall SHALL be sub-module bilin_lerp; FSM, phase and counters stay in top.

Verification
REQ-021 step=0x80, out_len=2, pair {10,30} -> out_pix 10, 20; one fifo_rd_en, on second issue; line_done once.
REQ-022 step=0x40, out_len=4, pair {0,255} -> 0, 64, 128, 191; fifo_rd_en only on fourth issue.
REQ-023 step=0x80, out_len=4, pairs {10,30},{40,80}, out_ready low 3 cycles after first out_valid -> out_pix holds 10, then 20, 40, 60, no loss or duplication.
REQ-024 fifo_empty=1 for 5 cycles after start -> no issue, no fifo_rd_en, out_valid 0; resumes 2 cycles after fifo_empty falls.
REQ-025 rst_n low during RUN after 1 of 4 outputs -> all outputs 0 immediately, IDLE, no line_done; new start with step=0x80 restarts at phase 0.
REQ-026 start with step=0 or out_len=0, and start while busy -> ignored, busy stays as before.
